rand_range_gen: RTL and testbench
=================================

Name: rand_range_gen

Overview:
- Sits directly downstream of the 8-bit LFSR random source.
- Drives the LFSR's random-request flag and captures its 8-bit output.
- Maps each captured byte onto 0..RANGE-1 without bias, using rejection sampling.
- Buffers results in a 4-entry FIFO behind a valid/ready output handshake.

Parameters:
- RANGE, 6: output modulus. Legal 2..255. LIMIT = 256 - (256 mod RANGE) is a derived localparam.
- WARMUP, 10: cycles to wait after reset or enable before the first request. Covers the LFSR's 8-cycle seed load.
- DEPTH, 4: output FIFO entries. Fixed power of 2, 2..8.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  generation enable.
- o_req  out  1  random request to LFSR (drives its rand flag).
- i_rand  in  8  LFSR random output.
- o_data  out  8  FIFO head value, 0..RANGE-1.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_err  out  1  sticky: LFSR delivered 0x00 (locked-up source).
- o_rej_cnt  out  8  rejected-sample counter; saturates at 255.

Behaviour:
- Reset (rst_n=0, async) forces the following, regardless of state:
  - state=IDLE, o_req=0, o_valid=0, o_data=0, o_err=0, o_rej_cnt=0.
  - FIFO pointers and count = 0; warm-up counter = 0; last-capture register = 0.
  - Any in-flight attempt is discarded.
- States: IDLE, WARM, REQ, CAP, CHK, ERR.
- IDLE:
  - If i_en=1, go to WARM and clear the warm-up counter.
- WARM:
  - Counter increments each cycle.
  - At count==WARMUP-1, go to REQ.
  - If i_en=0, go to IDLE.
- REQ:
  - o_req=1 for exactly this cycle.
  - Go to CAP unconditionally.
  - Only entered when FIFO count < DEPTH. If FIFO is full, stay in a REQ-wait hold with o_req=0 until space frees.
- CAP:
  - o_req=0.
  - i_rand is registered at the posedge leaving CAP.
  - Go to CHK.
- CHK evaluates the captured value v, in priority order:
  1. v==0x00: set o_err, go to ERR. No FIFO write.
  2. v==last-capture register: stale, nothing new from LFSR. Discard, no rej count, go to REQ.
  3. v>=LIMIT: reject. o_rej_cnt += 1 (saturating), update last-capture, go to REQ.
  4. Otherwise: write v mod RANGE into FIFO, update last-capture. Go to REQ if i_en=1, else IDLE.
- One attempt is 3 cycles (REQ, CAP, CHK). Minimum latency from i_en rise to first o_valid = WARMUP+3 cycles.
- ERR:
  - Absorbing. o_req=0.
  - FIFO continues to drain normally.
  - Only reset exits ERR.
- i_en:
  - Deasserting i_en mid-attempt lets the current attempt finish; the attempt's result is still written.
  - Re-enabling from IDLE re-runs WARM.
- FIFO:
  - Write in CHK case 4; read on o_valid & i_ready.
  - Simultaneous read and write when full: the write is impossible, because REQ is gated while full.
  - Simultaneous read and write when count is 1..DEPTH-1: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - o_data shows the head entry combinationally from FIFO storage; it is 0 when empty.
- Arithmetic:
  - Compare and modulo are 8-bit unsigned.
  - With RANGE a power of 2, LIMIT=256, so rejection never occurs.

Test Plan:
- Reset mid-CAP with o_valid=1 -> on rst_n fall, immediately o_req=0, o_valid=0, o_err=0, o_rej_cnt=0; after release, FSM in IDLE.
- RANGE=6, i_en=1, i_ready=1, model supplies 0x05 then 0x0D -> o_req pulses once per 3 cycles after 10 warm cycles; o_data=5, then 1; first o_valid at cycle 13 after i_en.
- RANGE=6, model supplies 0xFC, 0xFF, 0x11 -> o_rej_cnt=2; single FIFO output 5 (17 mod 6).
- Model repeats 0x2A twice, then 0x2B -> one output 0 (42 mod 6); second 0x2A discarded without counting; next output 1.
- i_ready=0, i_en=1 -> exactly 4 entries accepted; o_req stays 0 afterwards; one i_ready pulse -> one pop, then one new REQ pulse.
- Model supplies 0x00 -> o_err=1 in the cycle after CHK; o_req stays 0 forever; earlier FIFO entries still drain; only rst_n clears o_err.

Source files
------------

// File: rtl/rand_range_gen.sv
// rtl/rand_range_gen.sv - unbiased 0..RANGE-1 generator fed by an 8-bit LFSR, with output FIFO
module rand_range_gen #(
    parameter int RANGE  = 6,
    parameter int WARMUP = 10,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic       o_req,
    input  logic [7:0] i_rand,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_err,
    output logic [7:0] o_rej_cnt
);

    localparam int LIMIT = 256 - (256 % RANGE);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PW + 1;
    localparam int WW    = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    localparam logic [8:0]    LIMIT_V   = 9'(LIMIT);
    localparam logic [7:0]    RANGE_V   = 8'(RANGE);
    localparam logic [CW-1:0] DEPTH_V   = CW'(DEPTH);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

    typedef enum logic [2:0] {
        IDLE,
        WARM,
        REQ,
        CAP,
        CHK,
        ERR
    } state_t;

    state_t        state;
    logic [WW-1:0] warm_cnt;
    logic [7:0]    cap_q;
    logic [7:0]    last_q;
    logic          err_q;
    logic [7:0]    rej_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    mem [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic is_zero;
    logic is_stale;
    logic is_rej;

    assign full     = (count == DEPTH_V);
    assign pop      = (count != '0) && i_ready;
    assign is_zero  = (cap_q == 8'h00);
    assign is_stale = (cap_q == last_q);
    assign is_rej   = ({1'b0, cap_q} >= LIMIT_V);
    assign push     = (state == CHK) && !is_zero && !is_stale && !is_rej;

    // The REQ state doubles as the hold point while the FIFO is full
    assign o_req     = (state == REQ) && !full;
    assign o_valid   = (count != '0);
    assign o_data    = o_valid ? mem[rd_ptr] : 8'h00;
    assign o_err     = err_q;
    assign o_rej_cnt = rej_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_q % RANGE_V;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            warm_cnt <= '0;
            cap_q    <= 8'h00;
            last_q   <= 8'h00;
            err_q    <= 1'b0;
            rej_q    <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_en) begin
                        state    <= WARM;
                        warm_cnt <= '0;
                    end
                end
                WARM: begin
                    if (!i_en) begin
                        state <= IDLE;
                    end else if (warm_cnt == WARM_LAST) begin
                        state <= REQ;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (!full) begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    cap_q <= i_rand;
                    state <= CHK;
                end
                CHK: begin
                    if (is_zero) begin
                        err_q <= 1'b1;
                        state <= ERR;
                    end else if (is_stale) begin
                        state <= REQ;
                    end else if (is_rej) begin
                        if (rej_q != 8'hFF) begin
                            rej_q <= rej_q + 8'h01;
                        end
                        last_q <= cap_q;
                        state  <= REQ;
                    end else begin
                        last_q <= cap_q;
                        state  <= i_en ? REQ : IDLE;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_range_gen.sv
// tb/tb_rand_range_gen.sv - randomized and directed bench for rand_range_gen against a list-level model
module tb_rand_range_gen;

    localparam int RANGE  = 6;
    localparam int WARMUP = 10;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 256 - (256 % RANGE);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_cmd = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] i_rand = 8'h00;
    logic       o_req;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_err;
    logic [7:0] o_rej_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // LFSR stand-in: one value per request from stream[], i_en dropped once the plan is used up
    logic [7:0] stream [0:4095];
    int         plan_end = 0;
    int         served = 0;
    int         reqs = 0;
    int         extra_reqs = 0;
    int         cyc = 0;
    int         req_cyc [$];
    logic [7:0] got [$];

    logic [7:0] exp_q [$];
    int         exp_rej;
    bit         exp_err;
    int         gbase;
    int         rbase;

    rand_range_gen #(
        .RANGE (RANGE),
        .WARMUP(WARMUP),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (en_cmd && (served < plan_end)),
        .o_req    (o_req),
        .i_rand   (i_rand),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_err    (o_err),
        .o_rej_cnt(o_rej_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (o_req === 1'b1) begin
            reqs++;
            req_cyc.push_back(cyc);
            if (served < plan_end) begin
                i_rand = stream[served];
                served++;
            end else begin
                extra_reqs++;
                i_rand = 8'h01;
            end
        end
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            got.push_back(o_data);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the supplied byte list with the stale/reject/accept rules
    task automatic model_run(input int first, input int stop);
        int lastv;
        lastv   = 0;
        exp_rej = 0;
        exp_err = 1'b0;
        exp_q.delete();
        for (int k = first; k < stop; k++) begin
            int v;
            v = int'(stream[k]);
            if (!exp_err) begin
                if (v == 0) begin
                    exp_err = 1'b1;
                end else if (v != lastv) begin
                    if (v >= LIMIT) begin
                        if (exp_rej < 255) exp_rej++;
                    end else begin
                        exp_q.push_back(8'(v % RANGE));
                    end
                    lastv = v;
                end
            end
        end
    endtask

    task automatic do_reset();
        en_cmd  = 1'b0;
        i_ready = 1'b0;
        rst_n   = 1'b0;
        plan_end = served;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_plan(input logic [7:0] vals [$]);
        int base;
        base = plan_end;
        for (int k = 0; k < vals.size(); k++) stream[base + k] = vals[k];
        plan_end = base + vals.size();
        gbase = got.size();
        rbase = reqs;
        model_run(base, plan_end);
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd);
        int nout;
        for (int n = 0; n < budget; n++) begin
            if (served >= plan_end && (got.size() - gbase) >= exp_q.size() && !o_valid) break;
            @(posedge clk);
            #1 i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        i_ready = 1'b0;
        nout = got.size() - gbase;
        chk_eq({tag, "_nout"}, nout, exp_q.size());
        for (int k = 0; k < nout && k < exp_q.size(); k++)
            chk_eq($sformatf("%s_out%0d", tag, k), got[gbase + k], exp_q[k]);
        chk_eq({tag, "_rej"}, o_rej_cnt, exp_rej);
        chk_eq({tag, "_err"}, o_err, exp_err);
    endtask

    initial begin
        logic [7:0] v [$];
        int         c0;
        int         n;
        int         x0;

        do_reset();
        chk_eq("rst_req", o_req, 0);
        chk_eq("rst_valid", o_valid, 0);
        chk_eq("rst_data", o_data, 0);
        chk_eq("rst_err", o_err, 0);
        chk_eq("rst_rej", o_rej_cnt, 0);

        // Reset asserted while an attempt sits in CAP with data already buffered
        v = {8'hFC, 8'h05, 8'h07, 8'h09};
        load_plan(v);
        en_cmd = 1'b1;
        for (n = 0; n < 100 && !o_valid; n++) begin @(posedge clk); #1; end
        x0 = reqs;
        for (n = 0; n < 20 && reqs == x0; n++) begin @(negedge clk); #1; end
        @(posedge clk);
        #2;
        chk_eq("pre_rst_valid", o_valid, 1);
        chk_eq("pre_rst_rej", o_rej_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("async_rst_req", o_req, 0);
        chk_eq("async_rst_valid", o_valid, 0);
        chk_eq("async_rst_err", o_err, 0);
        chk_eq("async_rst_rej", o_rej_cnt, 0);
        en_cmd = 1'b0;
        plan_end = served;
        @(posedge clk);
        #1 rst_n = 1'b1;
        x0 = reqs;
        repeat (20) @(posedge clk);
        #1;
        chk_eq("post_rst_idle_reqs", reqs - x0, 0);
        chk_eq("post_rst_idle_valid", o_valid, 0);

        // Two accepted values: latency and request spacing
        do_reset();
        v = {8'h05, 8'h0D};
        load_plan(v);
        i_ready = 1'b1;
        en_cmd  = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        n = 0;
        while (!o_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk_eq("first_valid_lat", n, WARMUP + 3);
        drain("basic", 200, 1'b0);
        chk_eq("basic_reqs", req_cyc.size() - rbase, 2);
        if (req_cyc.size() >= rbase + 2) begin
            chk_eq("first_req_cycle", req_cyc[rbase] - c0, WARMUP);
            chk_eq("req_spacing", req_cyc[rbase + 1] - req_cyc[rbase], 3);
        end

        do_reset();
        v = {8'hFC, 8'hFF, 8'h11};
        load_plan(v);
        en_cmd = 1'b1;
        drain("reject", 300, 1'b0);
        chk_eq("reject_reqs", reqs - rbase, 3);

        do_reset();
        v = {8'h2A, 8'h2A, 8'h2B};
        load_plan(v);
        en_cmd = 1'b1;
        drain("stale", 300, 1'b0);

        // FIFO full back-pressure
        do_reset();
        v = {8'h11, 8'h13, 8'h17, 8'h19, 8'h23};
        load_plan(v);
        en_cmd = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk_eq("full_reqs", reqs - rbase, DEPTH);
        chk_eq("full_req_low", o_req, 0);
        chk_eq("full_valid", o_valid, 1);
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        for (n = 0; n < 10 && reqs - rbase == DEPTH; n++) begin @(posedge clk); #1; end
        chk_eq("after_pop_reqs", reqs - rbase, DEPTH + 1);
        chk_eq("after_pop_got", got.size() - gbase, 1);
        drain("full", 300, 1'b0);

        // Locked-up source
        do_reset();
        v = {8'h07, 8'h09, 8'h00};
        load_plan(v);
        en_cmd = 1'b1;
        for (n = 0; n < 100 && reqs - rbase < 3; n++) begin @(negedge clk); #1; end
        @(posedge clk);
        @(posedge clk);
        #1 chk_eq("err_in_chk", o_err, 0);
        @(posedge clk);
        #1 chk_eq("err_after_chk", o_err, 1);
        repeat (30) @(posedge clk);
        #1;
        chk_eq("err_no_req", reqs - rbase, 3);
        chk_eq("err_valid", o_valid, 1);
        drain("err", 200, 1'b0);
        do_reset();
        chk_eq("err_cleared", o_err, 0);

        // Random byte streams with random back-pressure
        for (int r = 0; r < 8; r++) begin
            logic [7:0] prev;
            logic [7:0] fin;
            do_reset();
            v.delete();
            prev = 8'h00;
            for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) v.push_back(prev);
                else v.push_back(8'($urandom_range(1, 255)));
                prev = v[v.size() - 1];
            end
            do fin = 8'($urandom_range(1, LIMIT - 1)); while (fin == prev);
            v.push_back(fin);
            x0 = extra_reqs;
            load_plan(v);
            en_cmd = 1'b1;
            drain($sformatf("rnd%0d", r), 2000, 1'b1);
            chk_eq($sformatf("rnd%0d_extra", r), extra_reqs - x0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
